// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver driven by an oversampling baud tick, with a valid/ack byte handshake.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report even-parity errors.
module uart_rx_frame #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic       Sys_clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] TCNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic [2:0]       bcnt, bcnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             deliver;
  logic             parity_calc;
  logic [7:0]       rx_data_nxt;
  logic             rx_valid_nxt, frame_err_nxt, parity_err_nxt, overrun_nxt;

`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_nxt;

  always_comb parity_calc = (^shreg) ^ par_bit;
`else
  always_comb parity_calc = 1'b0;
`endif

  // Frame sequencing: every counter and state change is gated by the baud tick.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    bcnt_nxt  = bcnt;
    shreg_nxt = shreg;
    deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nxt = par_bit;
`endif
    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            tcnt_nxt  = '0;
          end
        end
        START: begin
          if (tcnt == HALF_LAST) begin
            tcnt_nxt  = '0;
            bcnt_nxt  = '0;
            state_nxt = rxs ? IDLE : DATA;
          end else begin
            tcnt_nxt = tcnt + TCNT_ONE;
          end
        end
        DATA: begin
          if (tcnt == BIT_LAST) begin
            shreg_nxt = {rxs, shreg[7:1]};
            tcnt_nxt  = '0;
            bcnt_nxt  = bcnt + 3'd1;
            if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            tcnt_nxt = tcnt + TCNT_ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tcnt == BIT_LAST) begin
            par_bit_nxt = rxs;
            tcnt_nxt    = '0;
            state_nxt   = STOP;
          end else begin
            tcnt_nxt = tcnt + TCNT_ONE;
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop so a start edge in the back half of the stop bit is caught.
          if (tcnt == BIT_LAST) begin
            deliver   = 1'b1;
            tcnt_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            tcnt_nxt = tcnt + TCNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Delivery into the holding register, or overrun when the old byte is still unclaimed.
  always_comb begin
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = rx_valid;
    frame_err_nxt  = frame_err;
    parity_err_nxt = parity_err;
    overrun_nxt    = overrun;
    if (deliver) begin
      if (!rx_valid || rx_ack) begin
        rx_data_nxt    = shreg;
        frame_err_nxt  = ~rxs;
        parity_err_nxt = parity_calc;
        rx_valid_nxt   = 1'b1;
        overrun_nxt    = 1'b0;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (rx_ack && rx_valid) begin
      rx_valid_nxt = 1'b0;
      overrun_nxt  = 1'b0;
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rxs        <= rx_meta;
      state      <= state_nxt;
      tcnt       <= tcnt_nxt;
      bcnt       <= bcnt_nxt;
      shreg      <= shreg_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      frame_err  <= frame_err_nxt;
      parity_err <= parity_err_nxt;
      overrun    <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Testbench for uart_rx_frame: directed table, hand-written corner sequences and
// randomized frames checked against a frame-level model of the delivery rules.
module tb_uart_rx_frame;

  localparam int TPB    = 4;
  localparam int BITCLK = 16 * TPB;
`ifdef UART_RX_PARITY_EN
  localparam int NB     = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NB     = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  // Stop is sampled 8 ticks after the detect tick (one tick after the start edge
  // clears the synchronizer) plus one bit time per following bit.
  localparam int ACK_AT = (TPB + 8 * TPB + BITCLK * (NB - 1)) - 1;

  logic       Sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] m_data;
  logic       m_valid, m_fe, m_pe, m_ov;

  uart_rx_frame #(.OVERSAMPLE(16), .CNT_W(4)) dut (
    .Sys_clk(Sys_clk), .reset(reset), .baud_tick(baud_tick), .rx(rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  always #5 Sys_clk = ~Sys_clk;

  always @(negedge Sys_clk) begin
    cyc = cyc + 1;
    baud_tick = ((cyc % TPB) == 0);
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         ack_after;
    logic [7:0] exp_data;
    bit         exp_fe;
    bit         exp_ov;
  } vec_t;

  vec_t vecs[7];

  function automatic logic good_parity(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic modelReset();
    m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic modelDeliver(input logic [7:0] d, input bit stop, input bit pbit, input bit ack_same);
    if (!m_valid || ack_same) begin
      m_data  = d;
      m_fe    = ~stop;
      m_pe    = PAR_EN ? ((^d) ^ pbit) : 1'b0;
      m_valid = 1'b1;
      m_ov    = 1'b0;
    end else begin
      m_ov = 1'b1;
    end
  endtask

  task automatic modelAck();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ov    = 1'b0;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] ed, input logic ev,
                             input logic efe, input logic epe, input logic eov);
    checks++;
    if (rx_data !== ed || rx_valid !== ev || frame_err !== efe || parity_err !== epe || overrun !== eov) begin
      errors++;
      $display("[TB] FAIL %s: got data=%h valid=%b fe=%b pe=%b ov=%b, expected data=%h valid=%b fe=%b pe=%b ov=%b",
               name, rx_data, rx_valid, frame_err, parity_err, overrun, ed, ev, efe, epe, eov);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_data, m_valid, m_fe, m_pe, m_ov);
  endtask

  // Drives one frame bit-by-bit from a tick-aligned start, optionally pulsing rx_ack
  // or a reset at a given clock offset, then idles the line.
  task automatic applyStimulus(input logic [7:0] d, input bit stop, input bit pbit,
                               input int ack_at, input int abort_at);
    logic [10:0] line;
    line = 11'h7FF;
    line[0] = 1'b0;
    line[8:1] = d;
    if (PAR_EN) begin
      line[9]  = pbit;
      line[10] = stop;
    end else begin
      line[9] = stop;
    end
    do @(posedge Sys_clk); while (!baud_tick);
    @(negedge Sys_clk);
    for (int k = 0; k < NB * BITCLK; k++) begin
      if (abort_at >= 0 && k == abort_at) reset = 1'b1;
      if (abort_at >= 0 && k == abort_at + 2) reset = 1'b0;
      rx     = (abort_at >= 0 && k >= abort_at) ? 1'b1 : line[k / BITCLK];
      rx_ack = (k == ack_at);
      @(negedge Sys_clk);
    end
    rx = 1'b1;
    rx_ack = 1'b0;
    repeat (48) @(negedge Sys_clk);
  endtask

  task automatic doAck();
    @(negedge Sys_clk);
    rx_ack = 1'b1;
    @(negedge Sys_clk);
    rx_ack = 1'b0;
    modelAck();
  endtask

  initial begin
    logic [7:0] d;
    bit         stop, pbit, ack_same;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{8'h5A, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};

    modelReset();
    reset = 1'b1;
    repeat (5) @(negedge Sys_clk);
    reset = 1'b0;
    @(negedge Sys_clk);
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, vecs[i].stop, good_parity(vecs[i].data), -1, -1);
      modelDeliver(vecs[i].data, vecs[i].stop, good_parity(vecs[i].data), 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_data, 1'b1, vecs[i].exp_fe, 1'b0, vecs[i].exp_ov);
      if (vecs[i].ack_after) begin
        doAck();
        checkOutput($sformatf("vec%0d_ack", i), vecs[i].exp_data, 1'b0, vecs[i].exp_fe, 1'b0, 1'b0);
      end
    end

    // Glitch: 5 ticks low is shorter than the half-bit start qualification.
    do @(posedge Sys_clk); while (!baud_tick);
    @(negedge Sys_clk);
    rx = 1'b0;
    repeat (5 * TPB) @(negedge Sys_clk);
    rx = 1'b1;
    repeat (100) @(negedge Sys_clk);
    checkOutput("glitch", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1'b1, good_parity(8'h3C), -1, -1);
    modelDeliver(8'h3C, 1'b1, good_parity(8'h3C), 1'b0);
    checkOutput("after_glitch", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // Ack lands exactly on the stop-sample tick of a new frame while a byte is held.
    applyStimulus(8'h22, 1'b1, good_parity(8'h22), ACK_AT, -1);
    modelDeliver(8'h22, 1'b1, good_parity(8'h22), 1'b1);
    checkOutput("ack_same_cycle", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 4 with a byte still held.
    applyStimulus(8'h5A, 1'b1, good_parity(8'h5A), -1, 5 * BITCLK + BITCLK / 2);
    modelReset();
    checkOutput("reset_mid_frame", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(8'h07, 1'b1, 1'b0, -1, -1);
    modelDeliver(8'h07, 1'b1, 1'b0, 1'b0);
    checkOutput("parity_bad", 8'h07, 1'b1, 1'b0, PAR_EN, 1'b0);
    doAck();
    applyStimulus(8'h07, 1'b1, 1'b1, -1, -1);
    modelDeliver(8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput("parity_good", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    doAck();
    checkModel("parity_ack");

    for (int i = 0; i < 14; i++) begin
      d        = 8'($urandom);
      stop     = ($urandom % 5) != 0;
      pbit     = (($urandom % 4) == 0) ? ~good_parity(d) : good_parity(d);
      ack_same = ($urandom % 4) == 0;
      applyStimulus(d, stop, pbit, ack_same ? ACK_AT : -1, -1);
      modelDeliver(d, stop, pbit, ack_same);
      checkModel($sformatf("rand%0d", i));
      if (($urandom % 2) == 0) begin
        doAck();
        checkModel($sformatf("rand%0d_ack", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
